// File: rtl/tbird_signal_ctrl.sv
// tbird_signal_ctrl -- sequential turn-signal / hazard lamp controller.
//
// Each side has three lamps. A turn request ripples them outward one step per
// lamp tick (001 -> 011 -> 111 -> 000). A hazard request flashes both sides
// together (111, 111, 000, 000). A lamp tick occurs every TICK_DIV clock cycles.
//
// Parameters:
//   TICK_DIV    clock cycles per lamp step (1..65535)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   left_req    left-turn request (level)
//   right_req   right-turn request (level)
//   hazard_req  hazard request (level)
//   brake       brake pedal (level)
//   lamps_l     left lamps, registered, bit0 innermost
//   lamps_r     right lamps, registered, bit0 innermost
//   mode        current state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD
//   seq_done    one-cycle pulse on the final tick of each full sequence
//
// Build option:
//   TBIRD_BRAKE_EN  when defined, brake lights every side that is not
//                   signalling (ignored in HAZARD). When undefined, brake is
//                   accepted but has no effect.
module tbird_signal_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    input  logic       brake,
    output logic [2:0] lamps_l,
    output logic [2:0] lamps_r,
    output logic [1:0] mode,
    output logic       seq_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } state_t;

    localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);

    state_t      state, state_nxt, sel;
    logic [1:0]  step, step_nxt;
    logic [15:0] presc, presc_nxt;
    logic [2:0]  lamps_l_nxt, lamps_r_nxt;
    logic        tick;
    logic        brake_on;

`ifdef TBIRD_BRAKE_EN
    assign brake_on = brake;
`else
    logic unused_brake;
    assign unused_brake = brake;
    assign brake_on     = 1'b0;
`endif

    // Outward ripple pattern of the signalling side for a given step.
    function automatic logic [2:0] turn_pat(input logic [1:0] s);
        case (s)
            2'd1:    turn_pat = 3'b001;
            2'd2:    turn_pat = 3'b011;
            2'd3:    turn_pat = 3'b111;
            default: turn_pat = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] hazard_pat(input logic [1:0] s);
        hazard_pat = (s == 2'd1 || s == 2'd2) ? 3'b111 : 3'b000;
    endfunction

    assign tick = (presc == TICK_MAX);

    // Request priority: hazard (or both turn requests) beats a single turn.
    always_comb begin
        sel = IDLE;
        if (hazard_req || (left_req && right_req)) sel = HAZARD;
        else if (left_req)                         sel = LEFT;
        else if (right_req)                        sel = RIGHT;
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        presc_nxt = presc;
        if (state == IDLE) begin
            presc_nxt = '0;
            step_nxt  = 2'd0;
            if (sel != IDLE) begin
                state_nxt = sel;
                step_nxt  = 2'd1;
            end
        end else begin
            presc_nxt = tick ? '0 : presc + 16'd1;
            if (tick) begin
                if (step == 2'd0) begin
                    // End of sequence: re-select, so a held request repeats
                    // and a changed request switches only here.
                    state_nxt = sel;
                    step_nxt  = (sel == IDLE) ? 2'd0 : 2'd1;
                end else if (hazard_req && state != HAZARD) begin
                    // Hazard is the only request allowed to cut a turn short.
                    state_nxt = HAZARD;
                    step_nxt  = 2'd1;
                end else begin
                    step_nxt = step + 2'd1;
                end
            end
        end
    end

    // Lamps are registered from the next state so the pattern lines up with
    // the state it belongs to.
    always_comb begin
        lamps_l_nxt = brake_on ? 3'b111 : 3'b000;
        lamps_r_nxt = brake_on ? 3'b111 : 3'b000;
        case (state_nxt)
            LEFT:  lamps_l_nxt = turn_pat(step_nxt);
            RIGHT: lamps_r_nxt = turn_pat(step_nxt);
            HAZARD: begin
                lamps_l_nxt = hazard_pat(step_nxt);
                lamps_r_nxt = hazard_pat(step_nxt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            step    <= 2'd0;
            presc   <= '0;
            lamps_l <= 3'b000;
            lamps_r <= 3'b000;
        end else begin
            state   <= state_nxt;
            step    <= step_nxt;
            presc   <= presc_nxt;
            lamps_l <= lamps_l_nxt;
            lamps_r <= lamps_r_nxt;
        end
    end

    assign mode     = state;
    // Decoded from registers only, so it is glitch-free and high exactly
    // during the closing tick cycle of a sequence.
    assign seq_done = (state != IDLE) && tick && (step == 2'd0);

endmodule
